// File: rtl/fibo_index_if.sv
// Handshake bundle between a requester and the Fibonacci index search block.
interface fibo_index_if #(
  parameter int WIDTH   = 32,
  parameter int INDEX_W = 6
);
  logic               start;
  logic [WIDTH-1:0]   target;
  logic               busy;
  logic               done;
  logic               found;
  logic [INDEX_W-1:0] index;

  modport master (
    output start,
    output target,
    input  busy,
    input  done,
    input  found,
    input  index
  );

  modport slave (
    input  start,
    input  target,
    output busy,
    output done,
    output found,
    output index
  );
endinterface

// File: rtl/fibo_index.sv
// Inverse of the free-running Fibonacci generator: replays the recurrence
// one step per clock and reports the step at which the target value appears,
// is overtaken, or the next term would overflow WIDTH bits.
module fibo_index #(
  parameter int WIDTH   = 32,
  parameter int INDEX_W = 6
) (
  input  logic      clock,
  input  logic      reset,
  fibo_index_if.slave bus
);

  typedef enum logic {IDLE, SEARCH} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   prev, prev_nxt;
  logic [WIDTH-1:0]   cur, cur_nxt;
  logic [WIDTH-1:0]   tgt, tgt_nxt;
  logic [INDEX_W-1:0] cnt, cnt_nxt;
  logic               busy, busy_nxt;
  logic               done, done_nxt;
  logic               found, found_nxt;
  logic [INDEX_W-1:0] index, index_nxt;

  // Carry out of an unsigned WIDTH-bit add; marks the last representable term.
  function automatic logic carry_out(input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[WIDTH];
  endfunction

  // Next-state and result logic; every register holds unless updated below.
  always_comb begin
    state_nxt = state;
    prev_nxt  = prev;
    cur_nxt   = cur;
    tgt_nxt   = tgt;
    cnt_nxt   = cnt;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    found_nxt = found;
    index_nxt = index;
    case (state)
      IDLE: begin
        if (bus.start) begin
          tgt_nxt   = bus.target;
          prev_nxt  = '0;
          cur_nxt   = WIDTH'(1);
          cnt_nxt   = '0;
          busy_nxt  = 1'b1;
          state_nxt = SEARCH;
        end
      end
      SEARCH: begin
        // Equality is tested first so a target of 1 reports step 0, not 1.
        if (cur == tgt) begin
          found_nxt = 1'b1;
          index_nxt = cnt;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else if (cur > tgt) begin
          found_nxt = 1'b0;
          index_nxt = cnt;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else if (carry_out(cur, prev)) begin
          // Stop before the sum wraps, which could otherwise fake a match.
          found_nxt = 1'b0;
          index_nxt = cnt;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else begin
          prev_nxt = cur;
          cur_nxt  = cur + prev;
          cnt_nxt  = cnt + INDEX_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      prev  <= '0;
      cur   <= WIDTH'(1);
      tgt   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      found <= 1'b0;
      index <= '0;
    end else begin
      state <= state_nxt;
      prev  <= prev_nxt;
      cur   <= cur_nxt;
      tgt   <= tgt_nxt;
      cnt   <= cnt_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
      found <= found_nxt;
      index <= index_nxt;
    end
  end

  assign bus.busy  = busy;
  assign bus.done  = done;
  assign bus.found = found;
  assign bus.index = index;

endmodule
